// File: rtl/eth_capture_pkg.sv
// Shared types and constants for the Ethernet capture sequencer.
package eth_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StStatus,
    StPad
  } state_e;

  localparam logic [15:0] STAT_OK    = 16'h0200;
  localparam logic [15:0] STAT_CRC   = 16'h04FF;
  localparam logic [15:0] STAT_TRUNC = 16'h06EE;
  localparam logic [15:0] STAT_ABORT = 16'h08AA;
  localparam logic [15:0] BLANK      = 16'h0000;

  localparam logic [3:0] COLOR_RST = 4'h1;

endpackage

// File: rtl/ring_ptr.sv
// Row/column ring pointer with incremental write-address generation and per-frame row limit.
module ring_ptr #(
  parameter int unsigned AW        = 12,
  parameter int unsigned ROW_WORDS = 64,
  parameter int unsigned ROWS      = 32,
  parameter int unsigned ADDR_STEP = 2,
  parameter int unsigned MAX_ROWS  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          frame_done,
  output logic [AW-1:0] addr,
  output logic          last_col,
  output logic          row_limit
);

  localparam int unsigned ColW  = $clog2(ROW_WORDS);
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned UsedW = $clog2(MAX_ROWS + 1);

  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [UsedW-1:0] used_q, used_d;
  logic [AW-1:0]    addr_q, addr_d;

  assign last_col  = (col_q == ColW'(ROW_WORDS - 1));
  assign row_limit = (used_q == UsedW'(MAX_ROWS));
  assign addr      = addr_q;

  // Stepping off the last column lands on column 0 of the next row, which is
  // also one address step further unless the ring wraps back to row 0.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    used_d = used_q;
    addr_d = addr_q;
    if (step) begin
      if (last_col) begin
        col_d  = '0;
        used_d = used_q + UsedW'(1);
        if (row_q == RowW'(ROWS - 1)) begin
          row_d  = '0;
          addr_d = '0;
        end else begin
          row_d  = row_q + RowW'(1);
          addr_d = addr_q + AW'(ADDR_STEP);
        end
      end else begin
        col_d  = col_q + ColW'(1);
        addr_d = addr_q + AW'(ADDR_STEP);
      end
    end
    if (frame_done) begin
      used_d = UsedW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      used_q <= UsedW'(1);
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      used_q <= used_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/eth_capture_ctrl.sv
// Lays received Ethernet frames out as display rows, one word per byte, closed by a status word.
module eth_capture_ctrl
  import eth_capture_pkg::*;
#(
  parameter int unsigned AW        = 12,
  parameter int unsigned ROW_WORDS = 64,
  parameter int unsigned ROWS      = 32,
  parameter int unsigned ADDR_STEP = 2,
  parameter int unsigned MAX_ROWS  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    data,
  input  logic          valid,
  input  logic          sop,
  input  logic          eop,
  input  logic          crc_ok,
  input  logic          enable,
  output logic [AW-1:0] waddr,
  output logic [15:0]   wdata,
  output logic          we,
  output logic [15:0]   frame_count,
  output logic [15:0]   drop_count,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [3:0]    color_q, color_d;
  logic          trunc_q, trunc_d, abort_q, abort_d, crc_q, crc_d, pad_left_q, pad_left_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [15:0]   frame_count_q, drop_count_q;
  logic          frame_inc, drop_inc, step, frame_done, last_col, row_limit;
  logic [AW-1:0] ptr_addr;
  logic [15:0]   byte_word, status_word;
  logic          new_sop;

  assign new_sop   = valid & sop & enable;
  assign byte_word = {color_q, 4'h0, data};

  ring_ptr #(
    .AW        (AW),
    .ROW_WORDS (ROW_WORDS),
    .ROWS      (ROWS),
    .ADDR_STEP (ADDR_STEP),
    .MAX_ROWS  (MAX_ROWS)
  ) u_ring_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .frame_done (frame_done),
    .addr       (ptr_addr),
    .last_col   (last_col),
    .row_limit  (row_limit)
  );

  always_comb begin
    if (abort_q)      status_word = STAT_ABORT;
    else if (trunc_q) status_word = STAT_TRUNC;
    else if (crc_q)   status_word = STAT_OK;
    else              status_word = STAT_CRC;
  end

  always_comb begin
    state_d    = state_q;
    color_d    = color_q;
    trunc_d    = trunc_q;
    abort_d    = abort_q;
    crc_d      = crc_q;
    pad_left_d = pad_left_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    frame_inc  = 1'b0;
    drop_inc   = 1'b0;
    step       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (new_sop) begin
          we_d    = 1'b1;
          waddr_d = ptr_addr;
          wdata_d = byte_word;
          step    = 1'b1;
          state_d = StData;
        end
      end
      StData: begin
        if (valid && sop) begin
          abort_d  = 1'b1;
          drop_inc = enable;
          state_d  = StStatus;
        end else if (valid) begin
          if (!trunc_q) begin
            we_d    = 1'b1;
            waddr_d = ptr_addr;
            wdata_d = byte_word;
            // Out of rows: pointer stays on the final word so status overwrites it.
            if (last_col && row_limit) trunc_d = 1'b1;
            else                       step    = 1'b1;
          end
        end else if (eop) begin
          crc_d   = crc_ok;
          state_d = StStatus;
        end
      end
      StStatus: begin
        drop_inc   = new_sop;
        we_d       = 1'b1;
        waddr_d    = ptr_addr;
        wdata_d    = status_word;
        frame_inc  = 1'b1;
        pad_left_d = !last_col;
        step       = !last_col;
        state_d    = StPad;
      end
      StPad: begin
        drop_inc = new_sop;
        if (pad_left_q) begin
          we_d       = 1'b1;
          waddr_d    = ptr_addr;
          wdata_d    = BLANK;
          pad_left_d = !last_col;
          step       = !last_col;
        end else begin
          step       = 1'b1;
          frame_done = 1'b1;
          color_d    = {color_q[2:0], color_q[3]};
          trunc_d    = 1'b0;
          abort_d    = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      color_q       <= COLOR_RST;
      trunc_q       <= 1'b0;
      abort_q       <= 1'b0;
      crc_q         <= 1'b0;
      pad_left_q    <= 1'b0;
      we_q          <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      color_q    <= color_d;
      trunc_q    <= trunc_d;
      abort_q    <= abort_d;
      crc_q      <= crc_d;
      pad_left_q <= pad_left_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      if (frame_inc) frame_count_q <= frame_count_q + 16'd1;
      if (drop_inc && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign we          = we_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_eth_capture_ctrl.sv
// Bench for eth_capture_ctrl: frame table plus hand sequences, writes checked against a queue.
module tb_eth_capture_ctrl;
  import eth_capture_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned RW    = 64;
  localparam int unsigned ROWS0 = 32;
  localparam int unsigned MAXR0 = 4;
  localparam int unsigned ROWS1 = 2;
  localparam int unsigned MAXR1 = 1;

  typedef struct {
    int          len;
    bit          crc;
    logic [7:0]  seed;
    logic [15:0] status;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] data = '0;
  logic valid = 1'b0, sop = 1'b0, eop = 1'b0, crc_ok = 1'b0, enable = 1'b1, sel = 1'b0;
  logic [AW-1:0] waddr0, waddr1;
  logic [15:0] wdata0, wdata1, fc0, fc1, dc0, dc1;
  logic we0, we1, busy0, busy1;

  logic [AW+15:0] q0[$], q1[$];
  logic [AW+15:0] e0, e1;
  int n_checks = 0, n_pass = 0;
  int mrow[2], mfc[2], mdc[2];
  logic [3:0] mcolor[2];
  vec_t vecs[6];

  always #5 clk = ~clk;

  eth_capture_ctrl #(
    .AW(AW), .ROW_WORDS(RW), .ROWS(ROWS0), .ADDR_STEP(2), .MAX_ROWS(MAXR0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid & ~sel), .sop(sop),
    .eop(eop & ~sel), .crc_ok(crc_ok), .enable(enable), .waddr(waddr0), .wdata(wdata0),
    .we(we0), .frame_count(fc0), .drop_count(dc0), .busy(busy0)
  );

  eth_capture_ctrl #(
    .AW(AW), .ROW_WORDS(RW), .ROWS(ROWS1), .ADDR_STEP(2), .MAX_ROWS(MAXR1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid & sel), .sop(sop),
    .eop(eop & sel), .crc_ok(crc_ok), .enable(enable), .waddr(waddr1), .wdata(wdata1),
    .we(we1), .frame_count(fc1), .drop_count(dc1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (we0) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL dut0 write: got %h@%h, expected no write", wdata0, waddr0);
      end else begin
        e0 = q0.pop_front();
        check("dut0 write {addr,data}", 32'({waddr0, wdata0}), 32'(e0));
      end
    end
  end

  always @(negedge clk) begin
    if (we1) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL dut1 write: got %h@%h, expected no write", wdata1, waddr1);
      end else begin
        e1 = q1.pop_front();
        check("dut1 write {addr,data}", 32'({waddr1, wdata1}), 32'(e1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int d, input int row, input int col, input logic [15:0] w);
    int rows = (d == 0) ? ROWS0 : ROWS1;
    logic [AW-1:0] a;
    a = AW'(((row % rows) * RW + col) * 2);
    if (d == 0) q0.push_back({a, w});
    else        q1.push_back({a, w});
  endtask

  // Reference layout: byte i at linear word i of the frame, status right after the
  // last stored byte (or on the final permitted word), blanks to end of that row.
  task automatic expect_frame(input int d, input int len, input logic [7:0] seed,
                              input logic [15:0] status);
    int cap = RW * ((d == 0) ? MAXR0 : MAXR1);
    int sp;
    for (int i = 0; i < len && i < cap; i++)
      push_word(d, mrow[d] + i / RW, i % RW, {mcolor[d], 4'h0, seed + 8'(i * 17)});
    sp = (len >= cap) ? cap - 1 : len;
    push_word(d, mrow[d] + sp / RW, sp % RW, status);
    for (int c = sp % RW + 1; c < RW; c++) push_word(d, mrow[d] + sp / RW, c, BLANK);
    mrow[d]   = mrow[d] + sp / RW + 1;
    mcolor[d] = {mcolor[d][2:0], mcolor[d][3]};
    mfc[d]++;
  endtask

  task automatic drive_bytes(input int len, input logic [7:0] seed, input bit en);
    for (int i = 0; i < len; i++) begin
      valid  = 1'b1;
      sop    = (i == 0);
      enable = en;
      data   = seed + 8'(i * 17);
      tick();
    end
    valid  = 1'b0;
    sop    = 1'b0;
    enable = 1'b1;
  endtask

  task automatic send_frame(input int len, input logic [7:0] seed, input bit crc, input bit en);
    drive_bytes(len, seed, en);
    eop    = 1'b1;
    crc_ok = crc;
    tick();
    eop    = 1'b0;
    crc_ok = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((((d == 0) ? busy0 : busy1) || (((d == 0) ? q0.size() : q1.size()) != 0))
               && n < 500);
    tick();
    if (n >= 500) begin
      n_checks++;
      $display("FAIL dut%0d idle: still busy or writes pending after 500 cycles, expected idle", d);
    end
    check($sformatf("dut%0d frame_count", d), 32'((d == 0) ? fc0 : fc1), 32'(mfc[d]));
    check($sformatf("dut%0d drop_count", d), 32'((d == 0) ? dc0 : dc1), 32'(mdc[d]));
  endtask

  initial begin
    vecs[0] = '{3,   1'b1, 8'hAA, STAT_OK};
    vecs[1] = '{70,  1'b0, 8'h10, STAT_CRC};
    vecs[2] = '{64,  1'b1, 8'h20, STAT_OK};
    vecs[3] = '{63,  1'b1, 8'h30, STAT_OK};
    vecs[4] = '{260, 1'b1, 8'h40, STAT_TRUNC};
    vecs[5] = '{1,   1'b0, 8'h50, STAT_CRC};
    for (int d = 0; d < 2; d++) begin
      mrow[d] = 0; mfc[d] = 0; mdc[d] = 0; mcolor[d] = 4'h1;
    end

    tick(); tick(); tick();
    check("reset we", 32'(we0), 32'(0));
    check("reset waddr", 32'(waddr0), 32'(0));
    check("reset wdata", 32'(wdata0), 32'(0));
    check("reset frame_count", 32'(fc0), 32'(0));
    check("reset drop_count", 32'(dc0), 32'(0));
    check("reset busy", 32'(busy0), 32'(0));
    rst_n = 1'b1;
    tick();

    sel = 1'b0;
    foreach (vecs[k]) begin
      expect_frame(0, vecs[k].len, vecs[k].seed, vecs[k].status);
      send_frame(vecs[k].len, vecs[k].seed, vecs[k].crc, 1'b1);
      wait_idle(0);
    end

    // Capture disabled at sop: nothing written, nothing counted.
    send_frame(5, 8'h55, 1'b1, 1'b0);
    wait_idle(0);
    check("disabled busy", 32'(busy0), 32'(0));

    // sop arriving during PAD is dropped; the next frame lands on the next row.
    expect_frame(0, 3, 8'h01, STAT_OK);
    send_frame(3, 8'h01, 1'b1, 1'b1);
    tick(); tick(); tick();
    check("busy in pad", 32'(busy0), 32'(1));
    send_frame(3, 8'h90, 1'b1, 1'b1);
    mdc[0]++;
    wait_idle(0);
    expect_frame(0, 4, 8'h02, STAT_CRC);
    send_frame(4, 8'h02, 1'b0, 1'b1);
    wait_idle(0);

    // sop mid-DATA aborts the running frame and drops the new one.
    expect_frame(0, 2, 8'h60, STAT_ABORT);
    drive_bytes(2, 8'h60, 1'b1);
    send_frame(3, 8'h70, 1'b1, 1'b1);
    mdc[0]++;
    wait_idle(0);

    // Single-row limit: 80 bytes truncate, status replaces word 63; then ring wrap.
    sel = 1'b1;
    expect_frame(1, 80, 8'h01, STAT_TRUNC);
    send_frame(80, 8'h01, 1'b1, 1'b1);
    wait_idle(1);
    for (int k = 0; k < 2; k++) begin
      expect_frame(1, 3, 8'h33, STAT_OK);
      send_frame(3, 8'h33, 1'b1, 1'b1);
      wait_idle(1);
    end
    sel = 1'b0;

    // Walk dut0 to row ROWS-1 and one frame beyond so it wraps to address 0.
    while (mrow[0] <= int'(ROWS0)) begin
      expect_frame(0, 3, 8'hC0, STAT_OK);
      send_frame(3, 8'hC0, 1'b1, 1'b1);
      wait_idle(0);
    end

    // Reset mid-frame: outputs clear at once and capture restarts at row 0.
    for (int i = 0; i < 10; i++)
      push_word(0, mrow[0], i, {mcolor[0], 4'h0, 8'hE0 + 8'(i * 17)});
    drive_bytes(10, 8'hE0, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid reset we", 32'(we0), 32'(0));
    check("mid reset waddr", 32'(waddr0), 32'(0));
    check("mid reset wdata", 32'(wdata0), 32'(0));
    check("mid reset frame_count", 32'(fc0), 32'(0));
    check("mid reset drop_count", 32'(dc0), 32'(0));
    check("mid reset busy", 32'(busy0), 32'(0));
    rst_n = 1'b1;
    mrow[0] = 0; mcolor[0] = 4'h1; mfc[0] = 0; mdc[0] = 0;
    tick();
    expect_frame(0, 3, 8'hAA, STAT_OK);
    send_frame(3, 8'hAA, 1'b1, 1'b1);
    wait_idle(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_capture_ctrl.md
# eth_capture_ctrl

Sequencer between the RGMII receive byte stream and the display text-buffer write port. Lays each received Ethernet frame out as one or more display rows, one 16-bit word per byte. Closes each frame with a status word and blanks the rest of its last row. Runs in the receive clock domain and owns the buffer write address, row ring pointer and per-frame color tag.

## Interface

Parameters:
- `AW`, 12: display write address width.
- `ROW_WORDS`, 64: words per display row (≥ 2).
- `ROWS`, 32: rows in ring; `ROW_WORDS*ROWS*ADDR_STEP` ≤ 2^AW.
- `ADDR_STEP`, 2: waddr increment per word.
- `MAX_ROWS`, 4: maximum rows one frame may occupy.

Ports:
- `clk` in 1: receive clock (rx_clk); sole clock.
- `rst_n` in 1: synchronous, active-low reset.
- `data` in 8: received byte.
- `valid` in 1: `data` valid this cycle.
- `sop` in 1: first byte of frame; only meaningful with `valid`.
- `eop` in 1: end-of-frame strobe; never coincident with `valid`.
- `crc_ok` in 1: FCS result, valid with `eop`.
- `enable` in 1: capture enable, sampled only at `sop`.
- `waddr` out AW: buffer write address.
- `wdata` out 16: buffer write data.
- `we` out 1: buffer write strobe.
- `frame_count` out 16: frames captured, wraps.
- `drop_count` out 16: frames dropped, saturates at 16'hFFFF.
- `busy` out 1: state ≠ IDLE.

## Operation

- States: IDLE, DATA, STATUS, PAD.
- Counters:
  - `row` (0..ROWS-1): current ring row.
  - `col` (0..ROW_WORDS-1): current word within row.
  - `rows_used` (1..MAX_ROWS).
  - `color` (4 bits).
  - `trunc` flag.
- Word address is `(row*ROW_WORDS+col)*ADDR_STEP` mod 2^AW, maintained incrementally; no multiplier.
- IDLE
  - `valid&sop&enable`: write `{color,4'h0,data}` at (row,0) and go DATA.
  - `valid&sop&!enable`: no write, no count.
  - Any other input: ignored, including `eop` and `valid` without `sop`.
- DATA
  - Each `valid` writes `{color,4'h0,data}` and advances `col`.
  - At `col` = ROW_WORDS-1, `col` wraps to 0 and `row` advances mod ROWS, if `rows_used` < MAX_ROWS. Otherwise set `trunc`; later bytes are discarded and the pointer is held.
  - `eop`: go STATUS.
  - `valid&sop` in DATA (missing eop): go STATUS with abort status; the new frame is dropped.
- STATUS: writes one word at the current pointer, then goes PAD.
  - Abort: 16'h08AA.
  - Else if `trunc`: 16'h06EE.
  - Else if `crc_ok` (latched at eop): 16'h0200.
  - Else: 16'h04FF.
- Pointer overflow at status:
  - Pointer already past the last permitted word: status overwrites the final word of the frame.
  - `frame_count` increments in STATUS.
- PAD
  - Writes 16'h0000 at each remaining `col` through ROW_WORDS-1.
  - Then advances `row` mod ROWS, `col`←0, rotates `color` left by 1 bit, clears `trunc`, `rows_used`←1, and goes IDLE.
  - If STATUS landed on `col` = ROW_WORDS-1, PAD performs zero writes.
- Drops: `valid&sop&enable` seen in STATUS or PAD, or during DATA, increments `drop_count` (saturating). That frame's bytes are ignored until the next `sop` in IDLE.
- `enable` deassertion mid-frame has no effect.

## Timing

- All outputs registered. `we/waddr/wdata` follow the causing input by exactly 1 cycle.
- At most one write per cycle. STATUS occupies 1 cycle. PAD occupies ROW_WORDS-1-col_status cycles plus 1 bookkeeping cycle with `we`=0.
- `busy` is high from the cycle after the accepting `sop` through the PAD bookkeeping cycle.
- Reset values:
  - `waddr`=0, `wdata`=0, `we`=0.
  - `frame_count`=0, `drop_count`=0, `busy`=0.
  - `row`=0, `col`=0, `color`=4'h1, state IDLE.
- Reset mid-frame aborts with no status write; the next accepted frame starts at row 0.

## Structure

- Package `eth_capture_pkg` holds:
  - the state enum;
  - status constants STAT_OK=16'h0200, STAT_CRC=16'h04FF, STAT_TRUNC=16'h06EE, STAT_ABORT=16'h08AA, BLANK=16'h0000;
  - the reset color constant.
- One sub-module is natural: `ring_ptr`, holding row/col counters, incremental address generation and the row-limit compare.
- The saturating drop counter stays inline.

## Test plan

- Defaults; 3-byte frame 0xAA,0xBB,0xCC with `crc_ok`=1:
  - writes 16'h10AA@0, 16'h10BB@2, 16'h10CC@4, 16'h0200@6;
  - then 16'h0000 at 8..126;
  - `frame_count`=1; next frame starts at waddr 128 with color 4'h2.
- 70-byte frame with `crc_ok`=0: bytes fill row 0 and 6 words of row 1; 16'h04FF at (1,6); pad to (1,63); next frame starts at row 2.
- `MAX_ROWS`=1, 80-byte frame: 64 data words; last word (0,63) overwritten with 16'h06EE; bytes 65..80 produce no writes.
- `sop` 4 cycles after `eop` (during PAD): no data writes; `drop_count`=1. A later frame is captured normally at the next row.
- `sop` mid-DATA: 16'h08AA written, `drop_count`=1.
- `enable`=0 at `sop`: zero writes, counts unchanged.
- Ring wrap at row ROWS-1: the following frame writes at waddr 0.
- `rst_n` low mid-frame: all outputs at reset values the next cycle.
